// File: rtl/sample_serializer.sv
// sample_serializer: captures a 9-sample parallel frame in one cycle and
// replays it as a serial valid/ready stream, one sample per accepted beat.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no frame held, ready to capture a new frame
// SEND  | frame held in the buffer, emitting beats 0..8
module sample_serializer #(
    parameter int DATA_W       = 4,
    parameter bit OLDEST_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] samples_0,
    input  logic [DATA_W-1:0] samples_1,
    input  logic [DATA_W-1:0] samples_2,
    input  logic [DATA_W-1:0] samples_3,
    input  logic [DATA_W-1:0] samples_4,
    input  logic [DATA_W-1:0] samples_5,
    input  logic [DATA_W-1:0] samples_6,
    input  logic [DATA_W-1:0] samples_7,
    input  logic [DATA_W-1:0] samples_8,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [DATA_W-1:0] Data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [3:0]        out_index,
    output logic              busy,
    output logic [7:0]        frame_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Buffer slot that is emitted first / how the slot pointer moves per beat.
    localparam logic [3:0] FIRST_POS = OLDEST_FIRST ? 4'd8 : 4'd0;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q [9];
    logic [DATA_W-1:0] buf_d [9];
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        pos_q, pos_d;
    logic [7:0]        fc_q, fc_d;
    logic [DATA_W-1:0] data_mux;

    logic beat;
    logic last_beat;
    logic load;

    // Handshake decode: a beat completes on out_valid && out_ready, and a new
    // frame may be taken in IDLE or on the final beat of the current frame.
    always_comb begin
        beat       = (state_q == SEND) && out_ready;
        last_beat  = beat && (idx_q == 4'd8);
        load_ready = (state_q == IDLE) || last_beat;
        load       = load_valid && load_ready;
    end

    // Next-state, buffer capture, beat pointer and frame counter update.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        fc_d    = fc_q;

        if (last_beat) begin
            fc_d = fc_q + 8'd1;
        end

        if (load) begin
            state_d  = SEND;
            buf_d[0] = samples_0;
            buf_d[1] = samples_1;
            buf_d[2] = samples_2;
            buf_d[3] = samples_3;
            buf_d[4] = samples_4;
            buf_d[5] = samples_5;
            buf_d[6] = samples_6;
            buf_d[7] = samples_7;
            buf_d[8] = samples_8;
            idx_d    = 4'd0;
            pos_d    = FIRST_POS;
        end else if (last_beat) begin
            // Slot pointer is left alone so Data_out keeps the final sample.
            state_d = IDLE;
            idx_d   = 4'd0;
        end else if (beat) begin
            idx_d = idx_q + 4'd1;
            pos_d = OLDEST_FIRST ? (pos_q - 4'd1) : (pos_q + 4'd1);
        end
    end

    // State, buffer and counter registers; reset discards any held frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int i = 0; i < 9; i++) begin
                buf_q[i] <= '0;
            end
            idx_q <= 4'd0;
            pos_q <= 4'd0;
            fc_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 9; i++) begin
                buf_q[i] <= buf_d[i];
            end
            idx_q <= idx_d;
            pos_q <= pos_d;
            fc_q  <= fc_d;
        end
    end

    // Output sample comes only from the registered buffer, never from samples_*.
    always_comb begin
        case (pos_q)
            4'd0:    data_mux = buf_q[0];
            4'd1:    data_mux = buf_q[1];
            4'd2:    data_mux = buf_q[2];
            4'd3:    data_mux = buf_q[3];
            4'd4:    data_mux = buf_q[4];
            4'd5:    data_mux = buf_q[5];
            4'd6:    data_mux = buf_q[6];
            4'd7:    data_mux = buf_q[7];
            4'd8:    data_mux = buf_q[8];
            default: data_mux = buf_q[0];
        endcase
    end

    // Status outputs derived from the registered state.
    always_comb begin
        Data_out    = data_mux;
        busy        = (state_q == SEND);
        out_valid   = busy;
        out_index   = idx_q;
        out_last    = out_valid && (idx_q == 4'd8);
        frame_count = fc_q;
    end

endmodule
